gaussian_tile_dispatcher: RTL and testbench

Transmitter side of the per-tile Gaussian stream consumed by the splatting engine. The host supplies a tile command (tile indices plus Gaussian count), then loads that many Gaussian parameter sets into an internal buffer. The block then replays them to the engine over a valid/ready stream, with `end_of_tile` on the final beat and the tile origin `x`/`y` generated in fixed point. It sits between the host/sort front end and the coefficient calculator input of the engine.

---
 rtl/gs_pkg.sv | 27 ++
 rtl/gs_param_ram.sv | 27 ++
 rtl/gaussian_tile_dispatcher.sv | 216 +++++++++++++++++++++
 tb/tb_gaussian_tile_dispatcher.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gs_pkg.sv
// Shared types and defaults for the Gaussian tile dispatcher.
package gs_pkg;

   localparam int FRAC_BITS_DEF   = 16;
   localparam int DATA_WIDTH_DEF  = 32;
   localparam int COLOR_WIDTH_DEF = 32;
   localparam int OPAC_WIDTH_DEF  = 32;

   // One Gaussian parameter set. The dispatcher packs its buffer words in
   // this same field order.
   typedef struct packed {
      logic [DATA_WIDTH_DEF-1:0]  a;
      logic [DATA_WIDTH_DEF-1:0]  b;
      logic [DATA_WIDTH_DEF-1:0]  c;
      logic [DATA_WIDTH_DEF-1:0]  mu_x;
      logic [DATA_WIDTH_DEF-1:0]  mu_y;
      logic [COLOR_WIDTH_DEF-1:0] color;
      logic [OPAC_WIDTH_DEF-1:0]  opacity;
   } gaussian_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      STREAM = 2'd2
   } disp_state_e;

endpackage

// File: rtl/gs_param_ram.sv
// Simple dual-port buffer for Gaussian parameter sets: one write port and
// one synchronous read port with a single cycle of latency.
module gs_param_ram #(
   parameter int WIDTH = 224,
   parameter int DEPTH = 64,
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write port and registered read port.
   // NOTE: the array and read register are deliberately not reset; the
   // dispatcher only consumes rd_data when its own read-pending flag says so.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/gaussian_tile_dispatcher.sv
// Loads one tile's Gaussians from the host into a buffer, then replays them
// to the splatting engine over a valid/ready stream with the tile origin.
module gaussian_tile_dispatcher
   import gs_pkg::*;
#(
   parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
   parameter int FRAC_BITS     = FRAC_BITS_DEF,
   parameter int COLOR_WIDTH   = COLOR_WIDTH_DEF,
   parameter int OPAC_WIDTH    = OPAC_WIDTH_DEF,
   parameter int TILE_SIZE     = 16,
   parameter int MAX_GAUSSIANS = 64,
   parameter int CNT_W         = $clog2(MAX_GAUSSIANS + 1)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   tile_valid,
   output logic                   tile_ready,
   input  logic [15:0]            tile_x,
   input  logic [15:0]            tile_y,
   input  logic [15:0]            tile_count,
   input  logic                   wr_valid,
   output logic                   wr_ready,
   input  logic [DATA_WIDTH-1:0]  wr_a,
   input  logic [DATA_WIDTH-1:0]  wr_b,
   input  logic [DATA_WIDTH-1:0]  wr_c,
   input  logic [DATA_WIDTH-1:0]  wr_mu_x,
   input  logic [DATA_WIDTH-1:0]  wr_mu_y,
   input  logic [COLOR_WIDTH-1:0] wr_color,
   input  logic [OPAC_WIDTH-1:0]  wr_opacity,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   end_of_tile,
   output logic [DATA_WIDTH-1:0]  a,
   output logic [DATA_WIDTH-1:0]  b,
   output logic [DATA_WIDTH-1:0]  c,
   output logic [DATA_WIDTH-1:0]  x,
   output logic [DATA_WIDTH-1:0]  y,
   output logic [DATA_WIDTH-1:0]  mu_x,
   output logic [DATA_WIDTH-1:0]  mu_y,
   output logic [COLOR_WIDTH-1:0] color,
   output logic [OPAC_WIDTH-1:0]  opacity,
   output logic                   tile_done,
   output logic                   overflow
);

   localparam int PW    = 5 * DATA_WIDTH + COLOR_WIDTH + OPAC_WIDTH;
   localparam int AW    = (MAX_GAUSSIANS > 1) ? $clog2(MAX_GAUSSIANS) : 1;
   localparam int SHIFT = $clog2(TILE_SIZE) + FRAC_BITS;
   localparam logic [15:0] MAX_CNT16 = 16'(MAX_GAUSSIANS);

   disp_state_e           state;
   logic [15:0]           load_count;   // beats the host will send
   logic [15:0]           wr_cnt;       // beats received so far
   logic [CNT_W-1:0]      keep;         // beats actually stored
   logic [CNT_W-1:0]      tile_keep;
   logic [CNT_W-1:0]      n_beats;      // beats to emit (1 for an empty tile)
   logic [CNT_W-1:0]      rd_addr;
   logic [DATA_WIDTH-1:0] origin_x;
   logic [DATA_WIDTH-1:0] origin_y;

   logic [PW-1:0]         wr_data;
   logic [PW-1:0]         rd_data;
   logic [PW-1:0]         pipe_data;
   logic [PW-1:0]         skid_data;
   logic [PW-1:0]         out_data;
   logic                  rd_pend, rd_pend_last, rd_pend_null;
   logic                  skid_valid, skid_last;

   logic                  tile_fire, wr_fire, out_fire, out_free;
   logic                  wr_en, issue;
   logic [1:0]            occ;

   assign tile_ready = (state == IDLE);
   assign wr_ready   = (state == LOAD);
   assign tile_fire  = tile_valid & tile_ready;
   assign wr_fire    = wr_valid & wr_ready;
   assign out_fire   = out_valid & out_ready;
   assign out_free   = ~out_valid | out_ready;

   assign wr_data = {wr_a, wr_b, wr_c, wr_mu_x, wr_mu_y, wr_color, wr_opacity};
   assign wr_en   = wr_fire && (wr_cnt < 16'(keep));
   assign n_beats = (keep == '0) ? CNT_W'(1) : keep;

   // Entries held or in flight once this cycle's handshake retires; the
   // output register plus skid register can absorb at most two.
   assign occ   = 2'(out_valid) + 2'(skid_valid) + 2'(rd_pend) - 2'(out_fire);
   assign issue = (state == STREAM) && (rd_addr < n_beats) && (occ < 2'd2);

   // An empty tile streams one all-zero beat instead of buffer data.
   assign pipe_data = rd_pend_null ? '0 : rd_data;

   assign {a, b, c, mu_x, mu_y, color, opacity} = out_data;

   // Clamp the requested count to the buffer depth.
   // NOTE: default assignment first so every path drives tile_keep and no
   // latch is inferred.
   always_comb begin
      tile_keep = CNT_W'(tile_count);
      if (tile_count > MAX_CNT16) tile_keep = CNT_W'(MAX_GAUSSIANS);
   end

   gs_param_ram #(
      .WIDTH (PW),
      .DEPTH (MAX_GAUSSIANS),
      .AW    (AW)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_cnt[AW-1:0]),
      .wr_data (wr_data),
      .rd_en   (issue),
      .rd_addr (rd_addr[AW-1:0]),
      .rd_data (rd_data)
   );

   // Control FSM: command latch, load counting, read issue and tile completion.
   // NOTE: non-blocking assignments so every flop samples pre-edge values
   // regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         load_count <= '0;
         wr_cnt     <= '0;
         keep       <= '0;
         rd_addr    <= '0;
         origin_x   <= '0;
         origin_y   <= '0;
         overflow   <= 1'b0;
         tile_done  <= 1'b0;
      end else begin
         tile_done <= 1'b0;
         case (state)
            IDLE: begin
               if (tile_fire) begin
                  load_count <= tile_count;
                  keep       <= tile_keep;
                  wr_cnt     <= '0;
                  rd_addr    <= '0;
                  // Origin in fixed point: zero-extend, shift, truncate.
                  origin_x   <= DATA_WIDTH'({{DATA_WIDTH{1'b0}}, tile_x} << SHIFT);
                  origin_y   <= DATA_WIDTH'({{DATA_WIDTH{1'b0}}, tile_y} << SHIFT);
                  if (tile_count > MAX_CNT16) overflow <= 1'b1;
                  state <= (tile_count == 16'd0) ? STREAM : LOAD;
               end
            end
            LOAD: begin
               if (wr_fire) begin
                  wr_cnt <= wr_cnt + 16'd1;
                  if (wr_cnt == load_count - 16'd1) state <= STREAM;
               end
            end
            STREAM: begin
               if (issue) rd_addr <= rd_addr + CNT_W'(1);
               if (out_fire && end_of_tile) begin
                  state     <= IDLE;
                  tile_done <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Output pipeline: read-pending stage, skid register and output register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_pend      <= 1'b0;
         rd_pend_last <= 1'b0;
         rd_pend_null <= 1'b0;
         skid_valid   <= 1'b0;
         skid_last    <= 1'b0;
         skid_data    <= '0;
         out_valid    <= 1'b0;
         end_of_tile  <= 1'b0;
         out_data     <= '0;
         x            <= '0;
         y            <= '0;
      end else begin
         rd_pend <= issue;
         if (issue) begin
            rd_pend_last <= (rd_addr == n_beats - CNT_W'(1));
            rd_pend_null <= (keep == '0);
         end

         if (out_free) begin
            if (skid_valid) begin
               out_valid   <= 1'b1;
               out_data    <= skid_data;
               end_of_tile <= skid_last;
               x           <= origin_x;
               y           <= origin_y;
               skid_valid  <= rd_pend;
               if (rd_pend) begin
                  skid_data <= pipe_data;
                  skid_last <= rd_pend_last;
               end
            end else if (rd_pend) begin
               out_valid   <= 1'b1;
               out_data    <= pipe_data;
               end_of_tile <= rd_pend_last;
               x           <= origin_x;
               y           <= origin_y;
            end else begin
               out_valid   <= 1'b0;
               end_of_tile <= 1'b0;
            end
         end else if (rd_pend) begin
            // Output is stalled; park the arriving entry in the skid register.
            skid_valid <= 1'b1;
            skid_data  <= pipe_data;
            skid_last  <= rd_pend_last;
         end
      end
   end

endmodule

// File: tb/tb_gaussian_tile_dispatcher.sv
// Randomized bench for gaussian_tile_dispatcher against a queue-based model.
module tb_gaussian_tile_dispatcher;
   import gs_pkg::*;

   localparam int MAXG = 64;
   localparam int TS   = 16;
   localparam int FB   = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        tile_valid, tile_ready;
   logic [15:0] tile_x, tile_y, tile_count;
   logic        wr_valid, wr_ready;
   logic [31:0] wr_a, wr_b, wr_c, wr_mu_x, wr_mu_y, wr_color, wr_opacity;
   logic        out_valid, out_ready, end_of_tile;
   logic [31:0] a, b, c, x, y, mu_x, mu_y, color, opacity;
   logic        tile_done, overflow;

   always #5 clk = ~clk;

   gaussian_tile_dispatcher dut (
      .clk (clk), .rst_n (rst_n),
      .tile_valid (tile_valid), .tile_ready (tile_ready),
      .tile_x (tile_x), .tile_y (tile_y), .tile_count (tile_count),
      .wr_valid (wr_valid), .wr_ready (wr_ready),
      .wr_a (wr_a), .wr_b (wr_b), .wr_c (wr_c),
      .wr_mu_x (wr_mu_x), .wr_mu_y (wr_mu_y),
      .wr_color (wr_color), .wr_opacity (wr_opacity),
      .out_valid (out_valid), .out_ready (out_ready), .end_of_tile (end_of_tile),
      .a (a), .b (b), .c (c), .x (x), .y (y), .mu_x (mu_x), .mu_y (mu_y),
      .color (color), .opacity (opacity),
      .tile_done (tile_done), .overflow (overflow)
   );

   int n_vec = 0;
   int n_err = 0;

   gaussian_t   exp_q[$];
   logic [31:0] exp_x, exp_y;

   task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic gaussian_t out_beat();
      return gaussian_t'({a, b, c, mu_x, mu_y, color, opacity});
   endfunction

   // Tile origin in fixed point, from plain arithmetic.
   function automatic logic [31:0] origin(input logic [15:0] t);
      longint v;
      v = longint'(t) * TS * (longint'(1) << FB);
      return v[31:0];
   endfunction

   // Sends a tile command and its Gaussians; builds the expected beat list.
   // Returns at the falling edge right after the handshake that enters STREAM.
   task automatic send_tile(input logic [15:0] tx, input logic [15:0] ty, input logic [15:0] cnt);
      gaussian_t g;
      int i;
      int guard;
      exp_q.delete();
      exp_x = origin(tx);
      exp_y = origin(ty);
      check("tile_ready_idle", 320'(tile_ready), 320'(1));
      tile_valid = 1'b1;
      tile_x     = tx;
      tile_y     = ty;
      tile_count = cnt;
      @(posedge clk);
      @(negedge clk);
      tile_valid = 1'b0;
      check("tile_done_pulse_end", 320'(tile_done), 320'(0));
      check("tile_ready_busy", 320'(tile_ready), 320'(0));
      if (cnt == 16'd0) begin
         exp_q.push_back('0);
      end else begin
         i = 0;
         guard = 0;
         while (i < int'(cnt)) begin
            guard++;
            if (guard > 5000) begin
               check("load_timeout", 320'(0), 320'(1));
               break;
            end
            wr_valid = 1'b0;
            if (wr_ready && $urandom_range(3) != 0) begin
               g = gaussian_t'({$urandom(), $urandom(), $urandom(), $urandom(),
                                $urandom(), $urandom(), $urandom()});
               {wr_a, wr_b, wr_c, wr_mu_x, wr_mu_y, wr_color, wr_opacity} = g;
               wr_valid = 1'b1;
               if (i < MAXG) exp_q.push_back(g);
               i++;
            end
            @(posedge clk);
            @(negedge clk);
         end
         wr_valid = 1'b0;
         check("wr_ready_drop", 320'(wr_ready), 320'(0));
      end
   endtask

   // Drains the stream with out_ready high pct% of cycles. Returns at the
   // falling edge of the tile_done cycle.
   task automatic stream_tile(input int pct);
      int idx = 0;
      int since = 0;
      int guard = 0;
      int valid_cycles = 0;
      bit seen = 0;
      bit stalled = 0;
      bit done = 0;
      logic [319:0] snap = '0;
      while (!done) begin
         guard++;
         if (guard > 3000) begin
            check("stream_timeout", 320'(0), 320'(1));
            break;
         end
         if (stalled) begin
            check("stall_valid", 320'(out_valid), 320'(1));
            check("stall_hold", 320'({out_beat(), x, y, end_of_tile}), snap);
         end
         if (out_valid && !seen) begin
            seen = 1;
            check("first_latency", 320'(since), 320'(2));
         end
         if (seen) valid_cycles++;
         out_ready = ($urandom_range(99) < pct);
         stalled   = out_valid && !out_ready;
         snap      = 320'({out_beat(), x, y, end_of_tile});
         if (out_valid && out_ready) begin
            if (idx < exp_q.size()) begin
               check("beat_data", 320'(out_beat()), 320'(exp_q[idx]));
               check("beat_eot", 320'(end_of_tile), 320'(idx == exp_q.size() - 1));
            end else begin
               check("extra_beat", 320'(idx), 320'(exp_q.size()));
            end
            check("beat_x", 320'(x), 320'(exp_x));
            check("beat_y", 320'(y), 320'(exp_y));
            idx++;
            if (end_of_tile) done = 1;
         end
         @(posedge clk);
         since++;
         @(negedge clk);
      end
      out_ready = 1'b0;
      check("beat_count", 320'(idx), 320'(exp_q.size()));
      check("tile_done", 320'(tile_done), 320'(1));
      check("tile_ready_back", 320'(tile_ready), 320'(1));
      if (pct == 100) check("full_rate", 320'(valid_cycles), 320'(exp_q.size()));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int guard;
      rst_n = 1'b0;
      tile_valid = 1'b0; tile_x = '0; tile_y = '0; tile_count = '0;
      wr_valid = 1'b0;
      {wr_a, wr_b, wr_c, wr_mu_x, wr_mu_y, wr_color, wr_opacity} = '0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", 320'(out_valid), 320'(0));
      check("rst_eot", 320'(end_of_tile), 320'(0));
      check("rst_tile_done", 320'(tile_done), 320'(0));
      check("rst_overflow", 320'(overflow), 320'(0));
      check("rst_wr_ready", 320'(wr_ready), 320'(0));
      check("rst_tile_ready", 320'(tile_ready), 320'(1));
      check("rst_data", 320'({out_beat(), x, y}), 320'(0));
      rst_n = 1'b1;
      @(negedge clk);

      // Basic stream: origin (2,3), three Gaussians, full rate.
      send_tile(16'd2, 16'd3, 16'd3);
      check("basic_origin", 320'({exp_x, exp_y}), 320'({32'h0020_0000, 32'h0030_0000}));
      stream_tile(100);

      // Zero-count tile: a single null beat.
      send_tile(16'($urandom()), 16'($urandom()), 16'd0);
      stream_tile(100);
      check("no_overflow_yet", 320'(overflow), 320'(0));

      // Overflow: 70 writes, 64 beats.
      send_tile(16'($urandom()), 16'($urandom()), 16'd70);
      check("overflow_set", 320'(overflow), 320'(1));
      stream_tile(100);

      // Back-pressure.
      send_tile(16'($urandom()), 16'($urandom()), 16'd8);
      stream_tile(50);

      // Full-rate 64, then a tile accepted in the tile_done cycle.
      send_tile(16'($urandom()), 16'($urandom()), 16'd64);
      stream_tile(100);
      send_tile(16'($urandom()), 16'($urandom()), 16'($urandom_range(10, 1)));
      stream_tile(70);

      // Random tiles.
      for (int t = 0; t < 6; t++) begin
         send_tile(16'($urandom()), 16'($urandom()), 16'($urandom_range(20)));
         stream_tile(int'($urandom_range(100, 30)));
      end
      check("overflow_sticky", 320'(overflow), 320'(1));

      // Reset while beat 2 of 5 is pending.
      send_tile(16'($urandom()), 16'($urandom()), 16'd5);
      out_ready = 1'b0;
      guard = 0;
      while (!out_valid && guard < 20) begin
         guard++;
         @(posedge clk);
         @(negedge clk);
      end
      check("mid_beat1", 320'(out_beat()), 320'(exp_q[0]));
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check("mid_beat2_valid", 320'(out_valid), 320'(1));
      check("mid_beat2_data", 320'(out_beat()), 320'(exp_q[1]));
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("mid_rst_out_valid", 320'(out_valid), 320'(0));
      check("mid_rst_tile_ready", 320'(tile_ready), 320'(1));
      check("mid_rst_overflow", 320'(overflow), 320'(0));
      check("mid_rst_wr_ready", 320'(wr_ready), 320'(0));
      rst_n = 1'b1;
      @(negedge clk);

      // Recovery after reset.
      send_tile(16'($urandom()), 16'($urandom()), 16'd4);
      stream_tile(80);
      check("final_overflow", 320'(overflow), 320'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
